// File: rtl/rs_ccff_chain.sv
// Configuration-chain segment: serial shift register with a shadow MEM register
// that commits only on a full-frame UPDATE and can be reloaded for readback.
module rs_ccff_chain #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             D,
    input  logic             SE,
    input  logic             UPDATE,
    input  logic             CAPTURE,
    output logic             Q,
    output logic [WIDTH-1:0] MEM,
    output logic             DONE,
    output logic             ERR
);
    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr, sr_n, sr_shift, mem, mem_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             err, err_n;
    logic             full, illegal;

    generate
        if (WIDTH == 1) begin : g_w1
            assign sr_shift = D;
        end else begin : g_wn
            assign sr_shift = {sr[WIDTH-2:0], D};
        end
    endgenerate

    assign full    = (cnt == CW'(WIDTH));
    assign illegal = (SE & UPDATE) | (SE & CAPTURE) | (UPDATE & CAPTURE);

    always_ff @(posedge CK) begin
        if (RST) begin
            sr  <= '0;
            cnt <= '0;
            mem <= INIT;
            err <= 1'b0;
        end else begin
            sr  <= sr_n;
            cnt <= cnt_n;
            mem <= mem_n;
            err <= err_n;
        end
    end

    // Any conflicting request only flags the error; no state moves that cycle.
    always_comb begin
        sr_n  = sr;
        cnt_n = cnt;
        mem_n = mem;
        err_n = err;
        if (illegal) begin
            err_n = 1'b1;
        end else if (SE) begin
            sr_n  = sr_shift;
            cnt_n = full ? cnt : cnt + 1'b1;
        end else if (UPDATE) begin
            if (full) begin
                mem_n = sr;
                cnt_n = '0;
            end else begin
                err_n = 1'b1;
            end
        end else if (CAPTURE) begin
            sr_n  = mem;
            cnt_n = '0;
        end
    end

    always_comb begin
        Q    = sr[WIDTH-1];
        MEM  = mem;
        DONE = full;
        ERR  = err;
    end
endmodule

// File: tb/tb_rs_ccff_chain.sv
// Randomized + directed bench for rs_ccff_chain at WIDTH=8 and WIDTH=1,
// checked every cycle against a queue-based model of the chain.
module tb_rs_ccff_chain;
    logic       CK = 1'b0;
    logic       RST = 1'b1, D = 1'b0, SE = 1'b0, UPDATE = 1'b0, CAPTURE = 1'b0;
    logic       q8, done8, err8, q1, done1, err1;
    logic [7:0] mem8;
    logic [0:0] mem1;

    int n_cmp = 0;
    int n_bad = 0;

    // model: queue holds the chain oldest-first, so element 0 is what Q shows
    bit         mq[2][$];
    int         mcnt[2];
    logic [7:0] mmem[2];
    bit         merr[2];
    int         mw[2];
    logic [7:0] minit[2];

    rs_ccff_chain #(.WIDTH(8), .INIT(8'hA5)) dut8 (
        .CK(CK), .RST(RST), .D(D), .SE(SE), .UPDATE(UPDATE), .CAPTURE(CAPTURE),
        .Q(q8), .MEM(mem8), .DONE(done8), .ERR(err8));

    rs_ccff_chain #(.WIDTH(1), .INIT(1'b1)) dut1 (
        .CK(CK), .RST(RST), .D(D), .SE(SE), .UPDATE(UPDATE), .CAPTURE(CAPTURE),
        .Q(q1), .MEM(mem1), .DONE(done1), .ERR(err1));

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] frame_of(input int k);
        logic [7:0] v = '0;
        for (int i = 0; i < mw[k]; i++) v[mw[k]-1-i] = mq[k][i];
        return v;
    endfunction

    task automatic model_step(input bit r, input bit se, input bit up, input bit cap, input bit d);
        for (int k = 0; k < 2; k++) begin
            if (r) begin
                mq[k].delete();
                for (int i = 0; i < mw[k]; i++) mq[k].push_back(1'b0);
                mcnt[k] = 0;
                mmem[k] = minit[k];
                merr[k] = 1'b0;
            end else if (int'(se) + int'(up) + int'(cap) > 1) begin
                merr[k] = 1'b1;
            end else if (se) begin
                mq[k].push_back(d);
                void'(mq[k].pop_front());
                if (mcnt[k] < mw[k]) mcnt[k]++;
            end else if (up) begin
                if (mcnt[k] == mw[k]) begin
                    mmem[k] = frame_of(k);
                    mcnt[k] = 0;
                end else begin
                    merr[k] = 1'b1;
                end
            end else if (cap) begin
                for (int i = 0; i < mw[k]; i++) mq[k][i] = mmem[k][mw[k]-1-i];
                mcnt[k] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("q8",    q8,    mq[0][0]);
        chk("mem8",  mem8,  mmem[0]);
        chk("done8", done8, mcnt[0] == 8);
        chk("err8",  err8,  merr[0]);
        chk("q1",    q1,    mq[1][0]);
        chk("mem1",  mem1,  mmem[1][0]);
        chk("done1", done1, mcnt[1] == 1);
        chk("err1",  err1,  merr[1]);
    endtask

    task automatic cyc(input bit r, input bit se, input bit up, input bit cap, input bit d);
        @(negedge CK);
        RST = r; SE = se; UPDATE = up; CAPTURE = cap; D = d;
        @(posedge CK);
        model_step(r, se, up, cap, d);
        #1;
        check_all();
    endtask

    task automatic shift_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(0, 1, 0, 0, v[i]);
    endtask

    initial begin
        logic [7:0] got;
        mw[0] = 8; mw[1] = 1;
        minit[0] = 8'hA5; minit[1] = 8'h01;

        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("reset_mem", mem8, 8'hA5);
        chk("reset_q", q8, 1'b0);
        chk("reset_done", done8, 1'b0);
        chk("reset_err", err8, 1'b0);

        shift_bits(16'h003C, 8);
        chk("frame_done", done8, 1'b1);
        cyc(0, 0, 1, 0, 0);
        chk("frame_mem", mem8, 8'h3C);
        chk("frame_done_clr", done8, 1'b0);

        // readback: Q after capture then after each of the first 7 shifts
        cyc(0, 0, 0, 1, 0);
        got[7] = q8;
        for (int i = 6; i >= 0; i--) begin
            cyc(0, 1, 0, 0, $urandom_range(0, 1));
            got[i] = q8;
        end
        chk("readback", got, 8'h3C);
        cyc(0, 1, 0, 0, 0);
        chk("readback_done", done8, 1'b1);

        cyc(0, 0, 1, 0, 0);
        for (int i = 15; i >= 0; i--) begin
            logic [15:0] pat = 16'hBEEF;
            if (i <= 7) got[i] = q8;
            cyc(0, 1, 0, 0, pat[i]);
        end
        chk("pass_q", got, 8'hBE);
        cyc(0, 0, 1, 0, 0);
        chk("pass_mem", mem8, 8'hEF);

        // collision while FULL must leave SR untouched
        shift_bits(16'h005A, 8);
        cyc(0, 1, 1, 0, 1);
        chk("coll_mem", mem8, 8'hEF);
        chk("coll_err", err8, 1'b1);
        chk("coll_err1", err1, 1'b1);
        cyc(0, 0, 1, 0, 0);
        chk("coll_sr", mem8, 8'h5A);

        cyc(1, 0, 0, 0, 0);
        shift_bits(16'h0015, 5);
        cyc(0, 0, 1, 0, 0);
        chk("part_mem", mem8, 8'hA5);
        chk("part_err", err8, 1'b1);
        shift_bits(16'h0077, 8);
        cyc(0, 0, 1, 0, 0);
        chk("part_mem2", mem8, 8'h77);
        chk("part_err_sticky", err8, 1'b1);

        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        chk("w1_q", q1, 1'b1);
        cyc(0, 1, 0, 0, 0);
        chk("w1_q0", q1, 1'b0);

        for (int n = 0; n < 800; n++) begin
            bit r, se, up, cap;
            r   = ($urandom_range(0, 79) == 0);
            se  = ($urandom_range(0, 99) < 70);
            up  = ($urandom_range(0, 9) == 0);
            cap = ($urandom_range(0, 14) == 0);
            if ($urandom_range(0, 3) != 0 && (int'(se) + int'(up) + int'(cap) > 1)) begin
                se = 1'b0;
                if ($urandom_range(0, 1) == 1) up = 1'b0; else cap = 1'b0;
            end
            cyc(r, se, up, cap, $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
